// File: rtl/spart_fifo.sv
// spart_fifo: register-bus SPART with TX/RX FIFOs, configurable framing, sticky errors and a 16x baud generator.
module spart_fifo #(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int          STOP_BITS  = 1,
    parameter logic [15:0] DIV_RESET  = 16'd162
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic is_full(input logic [AW:0] w, input logic [AW:0] r);
        return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    logic              prev_cs, prev_rw;
    logic [1:0]        prev_addr;
    logic              acc, wr_acc, tx_push_req, rx_pop, ctl_wr, clr, flush, div_wr;
    logic [DATA_W-1:0] wdat;
    logic [15:0]       div, div_n, bcnt;
    logic              tick;
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wp, tx_rp, tx_wp_n, tx_rp_n, rx_wp, rx_rp, rx_wp_n, rx_rp_n;
    logic              tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_push, rx_push_req;
    logic              tx_ovf, rx_ovr, frm_err, par_err, frm_set, par_set, tx_idle;
    logic [DATA_W-1:0] rx_head;
    logic [7:0]        status, rd_data;
    state_t            tx_st, tx_st_n, rx_st, rx_st_n;
    logic [3:0]        tx_tc, tx_tc_n, rx_tc, rx_tc_n;
    logic [2:0]        tx_bc, tx_bc_n, rx_bc, rx_bc_n;
    logic [DATA_W-1:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n;
    logic              tx_pb, tx_pb_n, rx_pb, rx_pb_n, rx_s1, rx_s2;

    assign acc         = iocs && !(prev_cs && prev_rw == iorw && prev_addr == ioaddr);
    assign wr_acc      = acc && !iorw;
    assign wdat        = databus[DATA_W-1:0];
    assign tx_push_req = wr_acc && ioaddr == 2'b00;
    assign ctl_wr      = wr_acc && ioaddr == 2'b01;
    assign clr         = ctl_wr && databus[0];
    assign flush       = ctl_wr && databus[1];
    assign div_wr      = wr_acc && ioaddr[1];
    assign div_n       = !div_wr ? div : ioaddr[0] ? {databus, div[7:0]} : {div[15:8], databus};
    assign tick        = bcnt == 16'd0;

    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = is_full(tx_wp, tx_rp);
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = is_full(rx_wp, rx_rp);
    assign rx_pop   = acc && iorw && ioaddr == 2'b00 && !rx_empty;
    assign tx_push  = tx_push_req && !tx_full;
    assign rx_push  = rx_push_req && (!rx_full || rx_pop);
    assign tx_wp_n  = flush ? '0 : tx_wp + (AW+1)'(tx_push);
    assign tx_rp_n  = flush ? '0 : tx_rp + (AW+1)'(tx_pop);
    assign rx_wp_n  = flush ? '0 : rx_wp + (AW+1)'(rx_push);
    assign rx_rp_n  = flush ? '0 : rx_rp + (AW+1)'(rx_pop);
    assign rx_head  = rx_mem[rx_rp[AW-1:0]];
    assign tx_idle  = tx_st == IDLE && tx_empty;
    assign status   = {1'b0, tx_ovf, tx_idle, par_err, frm_err, rx_ovr, tbr, rda};
    assign rd_data  = ioaddr == 2'b00 ? (rx_empty ? 8'h00 : 8'(rx_head)) :
                      ioaddr == 2'b01 ? status : ioaddr == 2'b10 ? div[7:0] : div[15:8];
    assign databus  = (iocs && iorw) ? rd_data : 8'bz;
    assign txd      = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PARITY ? tx_pb : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cs   <= 1'b0;
            prev_rw   <= 1'b0;
            prev_addr <= 2'b00;
            div       <= DIV_RESET;
            bcnt      <= DIV_RESET;
            tx_wp     <= '0;
            tx_rp     <= '0;
            rx_wp     <= '0;
            rx_rp     <= '0;
            tbr       <= 1'b1;
            rda       <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_ovr    <= 1'b0;
            frm_err   <= 1'b0;
            par_err   <= 1'b0;
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
        end else begin
            prev_cs   <= iocs;
            prev_rw   <= iorw;
            prev_addr <= ioaddr;
            div       <= div_n;
            bcnt      <= (div_wr || tick) ? div_n : bcnt - 16'd1;
            tx_wp     <= tx_wp_n;
            tx_rp     <= tx_rp_n;
            rx_wp     <= rx_wp_n;
            rx_rp     <= rx_rp_n;
            tbr       <= !is_full(tx_wp_n, tx_rp_n);
            rda       <= rx_wp_n != rx_rp_n;
            tx_ovf    <= (tx_push_req && tx_full) || (tx_ovf && !clr);
            rx_ovr    <= (rx_push_req && rx_full && !rx_pop) || (rx_ovr && !clr);
            frm_err   <= frm_set || (frm_err && !clr);
            par_err   <= par_set || (par_err && !clr);
            rx_s1     <= rxd;
            rx_s2     <= rx_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp[AW-1:0]] <= wdat;
        if (rx_push)
            rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st <= IDLE;
            tx_tc <= '0;
            tx_bc <= '0;
            tx_sh <= '0;
            tx_pb <= 1'b1;
            rx_st <= IDLE;
            rx_tc <= '0;
            rx_bc <= '0;
            rx_sh <= '0;
            rx_pb <= 1'b0;
        end else begin
            tx_st <= tx_st_n;
            tx_tc <= tx_tc_n;
            tx_bc <= tx_bc_n;
            tx_sh <= tx_sh_n;
            tx_pb <= tx_pb_n;
            rx_st <= rx_st_n;
            rx_tc <= rx_tc_n;
            rx_bc <= rx_bc_n;
            rx_sh <= rx_sh_n;
            rx_pb <= rx_pb_n;
        end
    end

    always_comb begin
        tx_st_n = tx_st;
        tx_tc_n = tx_tc;
        tx_bc_n = tx_bc;
        tx_sh_n = tx_sh;
        tx_pb_n = tx_pb;
        tx_pop  = 1'b0;
        if (tick) begin
            tx_tc_n = tx_tc + 4'd1;
            case (tx_st)
                IDLE: begin
                    tx_tc_n = '0;
                    if (!tx_empty) begin
                        tx_pop  = 1'b1;
                        tx_st_n = START;
                        tx_sh_n = tx_mem[tx_rp[AW-1:0]];
                        tx_pb_n = ^tx_mem[tx_rp[AW-1:0]] ^ PARITY_ODD;
                    end
                end
                START: if (tx_tc == 4'd15) begin
                    tx_st_n = DATA;
                    tx_bc_n = '0;
                end
                DATA: if (tx_tc == 4'd15) begin
                    tx_sh_n = tx_sh >> 1;
                    tx_bc_n = tx_bc + 3'd1;
                    if (tx_bc == 3'(DATA_W - 1)) begin
                        tx_st_n = PARITY_EN ? PARITY : STOP;
                        tx_bc_n = '0;
                    end
                end
                PARITY: if (tx_tc == 4'd15) tx_st_n = STOP;
                STOP: if (tx_tc == 4'd15) begin
                    tx_bc_n = tx_bc + 3'd1;
                    if (tx_bc == 3'(STOP_BITS - 1)) tx_st_n = IDLE;
                end
                default: tx_st_n = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_st_n     = rx_st;
        rx_tc_n     = rx_tc;
        rx_bc_n     = rx_bc;
        rx_sh_n     = rx_sh;
        rx_pb_n     = rx_pb;
        rx_push_req = 1'b0;
        frm_set     = 1'b0;
        par_set     = 1'b0;
        if (tick) begin
            rx_tc_n = rx_tc + 4'd1;
            case (rx_st)
                IDLE: begin
                    rx_tc_n = '0;
                    if (!rx_s2) rx_st_n = START;
                end
                START: if (rx_tc == 4'd7) begin
                    rx_tc_n = '0;
                    rx_bc_n = '0;
                    rx_st_n = rx_s2 ? IDLE : DATA;
                end
                DATA: if (rx_tc == 4'd15) begin
                    rx_sh_n = {rx_s2, rx_sh[DATA_W-1:1]};
                    rx_bc_n = rx_bc + 3'd1;
                    if (rx_bc == 3'(DATA_W - 1)) rx_st_n = PARITY_EN ? PARITY : STOP;
                end
                PARITY: if (rx_tc == 4'd15) begin
                    rx_pb_n = rx_s2;
                    rx_st_n = STOP;
                end
                STOP: if (rx_tc == 4'd15) begin
                    rx_push_req = 1'b1;
                    frm_set     = !rx_s2;
                    par_set     = PARITY_EN && ((^rx_sh ^ rx_pb) != PARITY_ODD);
                    rx_st_n     = IDLE;
                end
                default: rx_st_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spart_fifo.sv
// tb_spart_fifo: directed/random bench for spart_fifo (even parity, depth 4) against a queue-based model.
module tb_spart_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1, iocs = 1'b0, iorw = 1'b1, loop = 1'b0, rxd_drv = 1'b1;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] wdata = 8'h00;
    wire  [7:0] databus;
    logic       rda, tbr, txd, rxd;
    int         checks = 0, errors = 0;
    logic [7:0] exp_q[$], fl_q[$], tq[$];
    logic       m_ovf = 1'b0, m_par = 1'b0, m_frm = 1'b0, m_ovr = 1'b0;
    logic [7:0] d, b;
    logic [9:0] fr;
    int         cnt;

    always #5 clk = ~clk;
    assign databus = (iocs && !iorw) ? wdata : 8'bz;
    assign rxd = loop ? txd : rxd_drv;

    spart_fifo #(.PARITY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] st_exp(input logic idle, input logic tb_ok);
        return {1'b0, m_ovf, idle, m_par, m_frm, m_ovr, tb_ok, exp_q.size() != 0};
    endfunction

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; wdata = v;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 v = databus;
        @(negedge clk);
        iocs = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        wr(2'b00, v);
        if (tq.size() < 4) begin
            tq.push_back(v);
            fl_q.push_back(v);
        end else m_ovf = 1'b1;
    endtask

    task automatic model_rx(input logic [7:0] v, input logic pe, input logic fe);
        m_par = m_par | pe;
        m_frm = m_frm | fe;
        if (exp_q.size() < 4) exp_q.push_back(v);
        else m_ovr = 1'b1;
    endtask

    task automatic wait_rda(input string tag);
        int n = 0;
        while (!rda && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk1(tag, rda, 1'b1);
    endtask

    task automatic wait_txd_low(input string tag);
        int n = 0;
        while (txd && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1(tag, txd, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] v, input logic pbit, input logic stop_ok);
        rxd_drv = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = v[i];
            repeat (32) @(negedge clk);
        end
        rxd_drv = pbit;
        repeat (32) @(negedge clk);
        rxd_drv = stop_ok;
        repeat (24) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("reset txd", txd, 1'b1);
        chk1("reset rda", rda, 1'b0);
        chk1("reset tbr", tbr, 1'b1);
        rd(2'b01, d); chk8("reset status", d, 8'h22);
        rd(2'b10, d); chk8("reset div lo", d, 8'hA2);
        rd(2'b11, d); chk8("reset div hi", d, 8'h00);
        wr(2'b10, 8'h01);
        wr(2'b11, 8'h00);
        rd(2'b10, d); chk8("div lo wr", d, 8'h01);
        rd(2'b11, d); chk8("div hi wr", d, 8'h00);
        loop = 1'b1;

        push(8'hA5);
        wait_txd_low("t1 start seen");
        tq.delete();
        cnt = 0;
        while (!txd && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk8("t1 start width", 8'(cnt), 8'd32);
        repeat (16) @(negedge clk);
        b = 8'hA5;
        fr = {1'b1, ^b, b};
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("t1 txd bit%0d", i), txd, fr[i]);
            repeat (32) @(negedge clk);
        end
        wait_rda("t1 rda rise");
        model_rx(fl_q.pop_front(), 1'b0, 1'b0);
        rd(2'b00, d); chk8("t1 data", d, exp_q.pop_front());
        chk1("t1 rda fall", rda, 1'b0);
        repeat (64) @(negedge clk);

        push(8'($urandom));
        wait_txd_low("t2 start seen");
        tq.delete();
        for (int i = 0; i < 4; i++) push(8'($urandom));
        chk1("t2 tbr full", tbr, tq.size() < 4);
        push(8'($urandom));
        rd(2'b01, d); chk8("t2 status ovf", d, st_exp(1'b0, 1'b0));
        tq.delete();
        for (int i = 0; i < 5; i++) begin
            wait_rda($sformatf("t2 rda %0d", i));
            model_rx(fl_q.pop_front(), 1'b0, 1'b0);
            rd(2'b00, d); chk8($sformatf("t2 data %0d", i), d, exp_q.pop_front());
        end
        repeat (400) @(negedge clk);
        chk1("t2 no extra frame", rda, 1'b0);
        rd(2'b01, d); chk8("t2 status idle", d, st_exp(1'b1, 1'b1));
        wr(2'b01, 8'h01);
        m_ovf = 1'b0;
        rd(2'b01, d); chk8("t2 status clr", d, st_exp(1'b1, 1'b1));

        push(8'($urandom));
        push(8'($urandom));
        repeat (900) @(negedge clk);
        tq.delete();
        model_rx(fl_q.pop_front(), 1'b0, 1'b0);
        model_rx(fl_q.pop_front(), 1'b0, 1'b0);
        rd(2'b01, d); chk8("t3 status", d, st_exp(1'b1, 1'b1));
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        #1 chk8("t3 hold head", databus, exp_q.pop_front());
        repeat (10) @(negedge clk);
        chk8("t3 hold next", databus, exp_q[0]);
        chk1("t3 hold rda", rda, 1'b1);
        iocs = 1'b0;
        rd(2'b00, d); chk8("t3 second", d, exp_q.pop_front());
        chk1("t3 rda fall", rda, 1'b0);

        loop = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_frame(b, ^b, 1'b1);
            model_rx(b, 1'b0, 1'b0);
        end
        rd(2'b01, d); chk8("t4 status ovr", d, st_exp(1'b1, 1'b1));
        wr(2'b01, 8'h01);
        m_ovr = 1'b0;
        rd(2'b01, d); chk8("t4 status clr", d, st_exp(1'b1, 1'b1));
        for (int i = 0; i < 4; i++) begin
            rd(2'b00, d); chk8($sformatf("t4 data %0d", i), d, exp_q.pop_front());
        end
        chk1("t4 rda empty", rda, 1'b0);
        rd(2'b00, d); chk8("t4 empty read", d, 8'h00);

        b = 8'h03;
        send_frame(b, 1'b1, 1'b1);
        model_rx(b, 1'b1 != ^b, 1'b0);
        rd(2'b01, d); chk8("t5 status par", d, st_exp(1'b1, 1'b1));
        rd(2'b00, d); chk8("t5 par data", d, exp_q.pop_front());
        b = 8'($urandom);
        send_frame(b, ^b, 1'b0);
        model_rx(b, 1'b0, 1'b1);
        rd(2'b01, d); chk8("t5 status frm", d, st_exp(1'b1, 1'b1));
        rd(2'b00, d); chk8("t5 frm data", d, exp_q.pop_front());

        loop = 1'b1;
        wr(2'b00, 8'($urandom));
        wait_txd_low("t6 start seen");
        repeat (10) @(negedge clk);
        chk1("t6 txd pre-reset", txd, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk1("t6 txd after rst", txd, 1'b1);
        rst = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
        rd(2'b01, d); chk8("t6 status", d, st_exp(1'b1, 1'b1));
        rd(2'b10, d); chk8("t6 div lo", d, 8'hA2);
        chk1("t6 rda", rda, 1'b0);
        chk1("t6 tbr", tbr, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spart_fifo.md
Name: spart_fifo

Overview:
Parametrised successor to the single-byte SPART. It keeps the same processor-side register bus (iocs/iorw/ioaddr/databus) and the rda/tbr handshake flags. New over the original:
- configurable character width, parity and stop bits
- TX and RX FIFOs of configurable depth
- sticky error flags (overrun, framing, parity, TX overflow) in a readable status register

It sits between the processor bus and the serial pins, using a programmable 16x-oversampling baud generator.

Parameters:
DATA_W, 8, character width in bits (5..8); unused high bus bits read 0, are ignored on write
FIFO_DEPTH, 4, entries per TX and RX FIFO (power of two, >=2)
PARITY_EN, 0, 1 = parity bit appended/checked after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (only when PARITY_EN=1)
STOP_BITS, 1, stop bits transmitted (1 or 2); receiver checks only the first
DIV_RESET, 16'd162, baud divisor value after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
iocs  in  1  chip select
iorw  in  1  1 = read, 0 = write
ioaddr  in  2  register select
databus  inout  8  bidirectional data; driven only when iocs&&iorw, else Z
rda  out  1  RX FIFO not empty
tbr  out  1  TX FIFO not full
txd  out  1  serial out, idles high
rxd  in  1  serial in, asynchronous

Behaviour:
Clock and reset:
- Single clock, synchronous active-high reset.

Reset state:
- txd=1, rda=0, tbr=1, databus=Z.
- Both FIFOs empty, all sticky flags 0, divisor=DIV_RESET, TX/RX FSMs in IDLE, rxd synchroniser flops =1.
- Reset mid-frame aborts the frame; txd=1 from the cycle after rst is sampled.

Register map:
- 00 R: RX FIFO head, zero-extended. Read when empty returns 0 and does not pop.
- 00 W: push databus[DATA_W-1:0] into the TX FIFO. Write when full drops the data and sets tx_ovf.
- 01 R: status = {0, tx_ovf, tx_idle, par_err, frm_err, rx_ovr, tbr, rda} (bit7..bit0).
- 01 W: bit0=1 clears all sticky flags; bit1=1 flushes both FIFOs. TX FSM finishes its current character.
- 10 R/W: divisor[7:0]. 11 R/W: divisor[15:8].
- Any divisor write reloads the baud counter.

Bus access timing:
- Reads are combinational.
- A pop (00 R) or push (00 W) happens on the first clk edge of a contiguous iocs assertion with the same iorw/ioaddr. Holding iocs for N cycles performs exactly one access.
- Changing ioaddr or iorw while iocs is held starts a new access.

Baud generator:
- Counter counts divisor..0; tick=1 for one clk on reaching 0, then reloads.
- One bit time = 16 ticks = 16*(divisor+1) clk.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: if TX FIFO is non-empty at a tick, pop the FIFO and go to START.
- Shift order: start bit 0, then DATA_W bits LSB first, then parity (if PARITY_EN), then STOP_BITS ones.
- Each state holds for 16 ticks.
- tx_idle=1 iff the FSM is in IDLE and the TX FIFO is empty.

RX FSM (IDLE, START, DATA, PARITY, STOP):
- Uses rxd after a 2-flop synchroniser.
- IDLE → START on a sampled falling level (0).
- START: at tick 8, if the line is 1, treat as a glitch and return to IDLE; otherwise go to DATA.
- Each subsequent bit is sampled 16 ticks after the previous sample (mid-bit).
- STOP: a sample of 0 sets frm_err. A parity mismatch sets par_err.
- The character is pushed to the RX FIFO even if flagged.
- If the FIFO is full it is discarded and rx_ovr is set.
- After STOP the FSM returns to IDLE immediately; a new start bit is accepted from the next sample.

FIFOs:
- Circular, with log2(FIFO_DEPTH)+1-bit pointers, so full and empty are distinguishable and wrap-around is correct.
- Push and pop in the same cycle: count unchanged.
- RX push to a full FIFO in the same cycle as a bus pop is accepted (no overrun).
- rda/tbr are registered and reflect FIFO state the cycle after the access.

Sticky flags:
- Clear only on a control write or reset.
- A set event in the same cycle as a clear wins (flag=1).

Test Plan:
- Reset → txd=1, rda=0, tbr=1, status reads 8'h22, divisor reads 162 (8'hA2/8'h00).
- Write divisor 10/11 = 8'h01/8'h00, push 8'hA5 with txd looped to rxd → txd low 32 clk, data bits 1,0,1,0,0,1,0,1 each 32 clk; rda rises after the stop bit; read 00 = 8'hA5; rda falls.
- Push FIFO_DEPTH+1 bytes (8'h01..8'h05) back-to-back, loopback → tbr=0 after the 4th push if TX has not yet popped; tx_ovf set if the 5th push is dropped. Reads return bytes in order with no loss or duplication across pointer wrap.
- Hold iocs=1, iorw=1, ioaddr=00 for 10 cycles with 2 bytes queued → exactly one pop, second byte remains, rda stays 1.
- Drive rxd externally with 5 frames while never reading (depth 4) → rx_ovr=1 and FIFO holds frames 1..4. Then write 01 = 8'h01 → status bit2=0.
- PARITY_EN=1, PARITY_ODD=0: inject 8'h03 with parity 1, then a frame with stop=0 → par_err=1 then frm_err=1. Assert rst mid-frame → txd=1 next cycle and all flags 0.
